// File: rtl/division_scheduler.sv
// Two-port front end for a shared iterative divider: round-robin grant, a one-entry
// result cache, and flush handling. Operation encoding: 0 DIV, 1 DIVU, 2 REM, 3 REMU.
module division_scheduler #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 6
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic                            clk_en_i,
  input  logic                            flush_i,
  input  logic [1:0]                      req_valid_i,
  output logic [1:0]                      req_ready_o,
  input  logic [1:0][DATA_WIDTH-1:0]      req_dividend_i,
  input  logic [1:0][DATA_WIDTH-1:0]      req_divisor_i,
  input  logic [1:0][1:0]                 req_operation_i,
  input  logic [1:0][TAG_WIDTH-1:0]       req_tag_i,
  output logic [DATA_WIDTH-1:0]           div_dividend_o,
  output logic [DATA_WIDTH-1:0]           div_divisor_o,
  output logic [1:0]                      div_operation_o,
  output logic                            div_valid_o,
  input  logic                            div_idle_i,
  input  logic                            div_valid_i,
  input  logic [DATA_WIDTH-1:0]           div_product_i,
  input  logic                            div_zero_i,
  output logic                            res_valid_o,
  input  logic                            res_ready_i,
  output logic [DATA_WIDTH-1:0]           res_product_o,
  output logic                            res_zero_o,
  output logic [TAG_WIDTH-1:0]            res_tag_o,
  output logic                            res_port_o
);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StRespond, StDrain} state_e;

  state_e                 state;
  logic                   ptr;
  logic [DATA_WIDTH-1:0]  hold_dividend, hold_divisor, res_product;
  logic [1:0]             hold_op;
  logic [TAG_WIDTH-1:0]   hold_tag;
  logic                   hold_port, res_zero;
  logic                   cache_valid, cache_zero;
  logic [DATA_WIDTH-1:0]  cache_dividend, cache_divisor, cache_product;
  logic [1:0]             cache_op;

  logic [1:0]             grant;
  logic                   gnt_port, cache_hit;
  logic [DATA_WIDTH-1:0]  sel_dividend, sel_divisor;
  logic [1:0]             sel_op;

  // A lone valid wins regardless of ptr; with both valid, ptr picks the favoured port.
  always_comb begin
    grant = 2'b00;
    if (rst_n_i && clk_en_i && !flush_i && state == StIdle) begin
      if (req_valid_i[0] && (!ptr || !req_valid_i[1])) grant = 2'b01;
      else if (req_valid_i[1])                          grant = 2'b10;
    end
  end

  assign gnt_port     = grant[1];
  assign sel_dividend = req_dividend_i[gnt_port];
  assign sel_divisor  = req_divisor_i[gnt_port];
  assign sel_op       = req_operation_i[gnt_port];
  assign cache_hit    = cache_valid && cache_dividend == sel_dividend &&
                        cache_divisor == sel_divisor && cache_op == sel_op;

  assign req_ready_o     = grant;
  assign div_valid_o     = rst_n_i && clk_en_i && state == StIssue && div_idle_i;
  assign div_dividend_o  = hold_dividend;
  assign div_divisor_o   = hold_divisor;
  assign div_operation_o = hold_op;
  assign res_valid_o     = state == StRespond;
  assign res_product_o   = res_product;
  assign res_zero_o      = res_zero;
  assign res_tag_o       = hold_tag;
  assign res_port_o      = hold_port;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state          <= StIdle;
      ptr            <= 1'b0;
      hold_dividend  <= '0;
      hold_divisor   <= '0;
      hold_op        <= '0;
      hold_tag       <= '0;
      hold_port      <= 1'b0;
      res_product    <= '0;
      res_zero       <= 1'b0;
      cache_valid    <= 1'b0;
      cache_dividend <= '0;
      cache_divisor  <= '0;
      cache_op       <= '0;
      cache_product  <= '0;
      cache_zero     <= 1'b0;
    end else if (clk_en_i) begin
      unique case (state)
        StIdle: begin
          if (grant != 2'b00) begin
            hold_dividend <= sel_dividend;
            hold_divisor  <= sel_divisor;
            hold_op       <= sel_op;
            hold_tag      <= req_tag_i[gnt_port];
            hold_port     <= gnt_port;
            ptr           <= !gnt_port;
            if (cache_hit) begin
              res_product <= cache_product;
              res_zero    <= cache_zero;
              state       <= StRespond;
            end else begin
              state <= StIssue;
            end
          end
        end
        StIssue: begin
          if (flush_i)         state <= StIdle;
          else if (div_idle_i) state <= StWait;
        end
        StWait: begin
          // A result arriving together with the flush is already spent, so skip StDrain.
          if (flush_i) begin
            state <= div_valid_i ? StIdle : StDrain;
          end else if (div_valid_i) begin
            res_product    <= div_product_i;
            res_zero       <= div_zero_i;
            cache_valid    <= 1'b1;
            cache_dividend <= hold_dividend;
            cache_divisor  <= hold_divisor;
            cache_op       <= hold_op;
            cache_product  <= div_product_i;
            cache_zero     <= div_zero_i;
            state          <= StRespond;
          end
        end
        StRespond: begin
          if (flush_i || res_ready_i) state <= StIdle;
        end
        StDrain: begin
          if (div_valid_i) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_division_scheduler.sv
// Scoreboard bench for division_scheduler: expected results are queued at grant time
// and compared when the result handshake completes; the bench plays the divider.
module tb_division_scheduler;
  localparam int DW = 32;
  localparam int TW = 6;

  typedef struct packed {
    logic [DW-1:0] product;
    logic          zero;
    logic [TW-1:0] tag;
    logic          port;
  } res_t;

  logic                 clk_i = 1'b0;
  logic                 rst_n_i, clk_en_i, flush_i;
  logic [1:0]           req_valid_i, req_ready_o;
  logic [1:0][DW-1:0]   req_dividend_i, req_divisor_i;
  logic [1:0][1:0]      req_operation_i;
  logic [1:0][TW-1:0]   req_tag_i;
  logic [DW-1:0]        div_dividend_o, div_divisor_o, div_product_i, res_product_o;
  logic [1:0]           div_operation_o;
  logic                 div_valid_o, div_idle_i, div_valid_i, div_zero_i;
  logic                 res_valid_o, res_ready_i, res_zero_o, res_port_o;
  logic [TW-1:0]        res_tag_o;

  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;
  res_t sb[$];

  division_scheduler #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .clk_en_i(clk_en_i), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_dividend_i(req_dividend_i), .req_divisor_i(req_divisor_i),
    .req_operation_i(req_operation_i), .req_tag_i(req_tag_i),
    .div_dividend_o(div_dividend_o), .div_divisor_o(div_divisor_o),
    .div_operation_o(div_operation_o), .div_valid_o(div_valid_o), .div_idle_i(div_idle_i),
    .div_valid_i(div_valid_i), .div_product_i(div_product_i), .div_zero_i(div_zero_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_product_o(res_product_o),
    .res_zero_o(res_zero_o), .res_tag_o(res_tag_o), .res_port_o(res_port_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    #2;
    if (div_valid_o === 1'b1) pulses++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // Reference divider: divide-by-zero gives all ones for DIV/DIVU and the dividend for REM/REMU.
  function automatic logic [DW:0] model(input logic [1:0] op, input logic [DW-1:0] a,
                                        input logic [DW-1:0] b);
    logic [DW-1:0] r;
    if (b == '0) r = op[1] ? a : '1;
    else begin
      case (op)
        2'd0:    r = $signed(a) / $signed(b);
        2'd1:    r = a / b;
        2'd2:    r = $signed(a) % $signed(b);
        default: r = a % b;
      endcase
    end
    return {b == '0, r};
  endfunction

  function automatic res_t expect_res(input logic [1:0] op, input logic [DW-1:0] a,
                                      input logic [DW-1:0] b, input logic [TW-1:0] tag,
                                      input logic port);
    logic [DW:0] m;
    m = model(op, a, b);
    return {m[DW-1:0], m[DW], tag, port};
  endfunction

  function automatic res_t cur_res();
    return {res_product_o, res_zero_o, res_tag_o, res_port_o};
  endfunction

  task automatic drive_req(input int p, input logic [1:0] op, input logic [DW-1:0] a,
                           input logic [DW-1:0] b, input logic [TW-1:0] tag);
    req_valid_i[p]     = 1'b1;
    req_operation_i[p] = op;
    req_dividend_i[p]  = a;
    req_divisor_i[p]   = b;
    req_tag_i[p]       = tag;
  endtask

  // Called at a negedge; returns at the negedge just after the grant edge.
  task automatic wait_grant(input int p, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (!ok && n < 50) begin
      #1;
      if (req_ready_o[p]) ok = 1'b1;
      @(negedge clk_i);
      n++;
    end
    req_valid_i[p] = 1'b0;
  endtask

  // Waits for the start pulse, then returns a result computed from the DUT's operand outputs.
  task automatic serve_div(input int delay, output bit ok);
    int n = 0;
    logic [DW:0] m;
    ok = 1'b0;
    while (!ok && n < 20) begin
      #1;
      if (div_valid_o) ok = 1'b1;
      else begin
        @(negedge clk_i);
        n++;
      end
    end
    @(negedge clk_i);
    repeat (delay) @(negedge clk_i);
    m = model(div_operation_o, div_dividend_o, div_divisor_o);
    div_valid_i   = 1'b1;
    div_product_i = m[DW-1:0];
    div_zero_i    = m[DW];
    @(negedge clk_i);
    div_valid_i = 1'b0;
  endtask

  task automatic collect(output res_t got, output bit ok);
    int n = 0;
    ok  = 1'b0;
    got = '0;
    while (!ok && n < 50) begin
      #1;
      if (res_valid_o) begin
        ok          = 1'b1;
        got         = cur_res();
        res_ready_i = 1'b1;
      end
      @(negedge clk_i);
      n++;
    end
    res_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; clk_en_i = 1'b1; flush_i = 1'b0; req_valid_i = '0;
    req_dividend_i = '0; req_divisor_i = '0; req_operation_i = '0; req_tag_i = '0;
    div_idle_i = 1'b1; div_valid_i = 1'b0; div_product_i = '0; div_zero_i = 1'b0;
    res_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    checks++; if (res_valid_o !== 1'b0) begin errors++;
      $display("FAIL reset_res_valid: got %b, expected 0", res_valid_o); end
    checks++; if (req_ready_o !== 2'b00) begin errors++;
      $display("FAIL reset_req_ready: got %b, expected 00", req_ready_o); end
    checks++; if (div_valid_o !== 1'b0) begin errors++;
      $display("FAIL reset_div_valid: got %b, expected 0", div_valid_o); end
    checks++; if (cur_res() !== res_t'(0)) begin errors++;
      $display("FAIL reset_res_outputs: got %h, expected 0", cur_res()); end
    checks++; if ({div_dividend_o, div_divisor_o, div_operation_o} !== '0) begin errors++;
      $display("FAIL reset_div_outputs: got %h/%h/%h, expected 0", div_dividend_o,
               div_divisor_o, div_operation_o); end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_arbitration();
    bit ok; res_t got, exp;
    drive_req(0, 2'd1, 50, 5, 1);
    drive_req(1, 2'd3, 50, 7, 2);
    #1;
    checks++; if (req_ready_o !== 2'b01) begin errors++;
      $display("FAIL arb_first_grant: got %b, expected 01", req_ready_o); end
    @(negedge clk_i);
    req_valid_i[0] = 1'b0;
    sb.push_back(expect_res(2'd1, 50, 5, 1, 1'b0));
    #1;
    checks++; if (req_ready_o !== 2'b00) begin errors++;
      $display("FAIL arb_busy_ready: got %b, expected 00", req_ready_o); end
    serve_div(1, ok);
    exp = sb.pop_front(); collect(got, ok);
    checks++; if (!ok || got !== exp) begin errors++;
      $display("FAIL arb_port0_result: got %h (ok=%0d), expected %h", got, ok, exp); end
    drive_req(0, 2'd0, 32'hFFFF_FFEC, 3, 3);
    #1;
    checks++; if (req_ready_o !== 2'b10) begin errors++;
      $display("FAIL arb_second_grant: got %b, expected 10", req_ready_o); end
    @(negedge clk_i);
    req_valid_i[1] = 1'b0;
    sb.push_back(expect_res(2'd3, 50, 7, 2, 1'b1));
    serve_div(1, ok);
    exp = sb.pop_front(); collect(got, ok);
    checks++; if (!ok || got !== exp) begin errors++;
      $display("FAIL arb_port1_result: got %h (ok=%0d), expected %h", got, ok, exp); end
    wait_grant(0, ok);
    sb.push_back(expect_res(2'd0, 32'hFFFF_FFEC, 3, 3, 1'b0));
    serve_div(0, ok);
    exp = sb.pop_front(); collect(got, ok);
    checks++; if (!ok || got !== exp) begin errors++;
      $display("FAIL arb_signed_div: got %h (ok=%0d), expected %h", got, ok, exp); end
  endtask

  task automatic test_miss();
    bit ok; res_t got, exp; int p0;
    div_idle_i = 1'b0;
    p0 = pulses;
    drive_req(1, 2'd1, 100, 7, 5);
    wait_grant(1, ok);
    sb.push_back(expect_res(2'd1, 100, 7, 5, 1'b1));
    #1;
    checks++; if (div_valid_o !== 1'b0) begin errors++;
      $display("FAIL miss_busy_divider: got div_valid %b, expected 0", div_valid_o); end
    checks++; if ({div_dividend_o, div_divisor_o, div_operation_o} !== {32'd100, 32'd7, 2'd1})
      begin errors++;
      $display("FAIL miss_operands: got %0d/%0d/%0d, expected 100/7/1", div_dividend_o,
               div_divisor_o, div_operation_o); end
    @(negedge clk_i);
    div_idle_i = 1'b1;
    #1;
    checks++; if (div_valid_o !== 1'b1) begin errors++;
      $display("FAIL miss_issue_pulse: got %b, expected 1", div_valid_o); end
    serve_div(2, ok);
    #1;
    checks++; if (res_valid_o !== 1'b1) begin errors++;
      $display("FAIL miss_latency: got res_valid %b, expected 1", res_valid_o); end
    exp = sb.pop_front(); collect(got, ok);
    checks++; if (!ok || got !== exp) begin errors++;
      $display("FAIL miss_result: got %h (ok=%0d), expected %h", got, ok, exp); end
    checks++; if (pulses - p0 !== 1) begin errors++;
      $display("FAIL miss_pulse_count: got %0d, expected 1", pulses - p0); end
  endtask

  task automatic test_hit();
    bit ok; res_t got, exp; int p0;
    p0 = pulses;
    drive_req(0, 2'd1, 100, 7, 9);
    wait_grant(0, ok);
    sb.push_back(expect_res(2'd1, 100, 7, 9, 1'b0));
    #1;
    checks++; if (res_valid_o !== 1'b1) begin errors++;
      $display("FAIL hit_latency: got res_valid %b, expected 1", res_valid_o); end
    exp = sb.pop_front(); collect(got, ok);
    checks++; if (!ok || got !== exp) begin errors++;
      $display("FAIL hit_result: got %h (ok=%0d), expected %h", got, ok, exp); end
    checks++; if (pulses !== p0) begin errors++;
      $display("FAIL hit_no_pulse: got %0d pulses, expected 0", pulses - p0); end
  endtask

  task automatic test_div_zero();
    bit ok; res_t got, exp; int p0;
    drive_req(0, 2'd0, 10, 0, 3);
    wait_grant(0, ok);
    sb.push_back(expect_res(2'd0, 10, 0, 3, 1'b0));
    serve_div(1, ok);
    exp = sb.pop_front(); collect(got, ok);
    checks++; if (!ok || got !== exp) begin errors++;
      $display("FAIL zero_miss_result: got %h (ok=%0d), expected %h", got, ok, exp); end
    p0 = pulses;
    drive_req(1, 2'd0, 10, 0, 4);
    wait_grant(1, ok);
    sb.push_back(expect_res(2'd0, 10, 0, 4, 1'b1));
    #1;
    checks++; if ({res_valid_o, res_zero_o} !== 2'b11) begin errors++;
      $display("FAIL zero_hit_flag: got valid/zero %b%b, expected 11", res_valid_o,
               res_zero_o); end
    exp = sb.pop_front(); collect(got, ok);
    checks++; if (!ok || got !== exp || pulses !== p0) begin errors++;
      $display("FAIL zero_hit_result: got %h pulses %0d, expected %h pulses 0", got,
               pulses - p0, exp); end
  endtask

  task automatic test_flush_wait();
    bit ok; res_t got, exp;
    drive_req(0, 2'd2, 77, 5, 7);
    wait_grant(0, ok);
    @(negedge clk_i);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    drive_req(1, 2'd2, 77, 5, 8);
    #1;
    checks++; if (req_ready_o !== 2'b00) begin errors++;
      $display("FAIL drain_ready: got %b, expected 00", req_ready_o); end
    @(negedge clk_i);
    div_valid_i = 1'b1; div_product_i = 3; div_zero_i = 1'b0;
    @(negedge clk_i);
    div_valid_i = 1'b0;
    #1;
    checks++; if (res_valid_o !== 1'b0) begin errors++;
      $display("FAIL drain_discard: got res_valid %b, expected 0", res_valid_o); end
    wait_grant(1, ok);
    sb.push_back(expect_res(2'd2, 77, 5, 8, 1'b1));
    #1;
    checks++; if ({res_valid_o, div_valid_o} !== 2'b01) begin errors++;
      $display("FAIL drain_not_cached: got valid/issue %b%b, expected 01", res_valid_o,
               div_valid_o); end
    serve_div(1, ok);
    exp = sb.pop_front(); collect(got, ok);
    checks++; if (!ok || got !== exp) begin errors++;
      $display("FAIL drain_rerequest: got %h (ok=%0d), expected %h", got, ok, exp); end
  endtask

  task automatic test_stall();
    bit ok; res_t got, exp, snap;
    drive_req(1, 2'd1, 1000, 10, 11);
    wait_grant(1, ok);
    sb.push_back(expect_res(2'd1, 1000, 10, 11, 1'b1));
    serve_div(1, ok);
    drive_req(0, 2'd1, 1000, 10, 12);
    exp = sb.pop_front();
    #1;
    snap = cur_res();
    for (int i = 0; i < 5; i++) begin
      checks++; if (!res_valid_o || cur_res() !== exp || req_ready_o !== 2'b00) begin
        errors++;
        $display("FAIL stall_hold_%0d: got valid %b res %h ready %b, expected 1 %h 00", i,
                 res_valid_o, cur_res(), req_ready_o, exp); end
      @(negedge clk_i);
      #1;
    end
    res_ready_i = 1'b1;
    #1;
    checks++; if (req_ready_o !== 2'b00 || snap !== exp) begin errors++;
      $display("FAIL stall_accept: got ready %b res %h, expected 00 %h", req_ready_o, snap,
               exp); end
    @(negedge clk_i);
    res_ready_i = 1'b0;
    #1;
    checks++; if (req_ready_o !== 2'b01) begin errors++;
      $display("FAIL stall_resume: got %b, expected 01", req_ready_o); end
    @(negedge clk_i);
    req_valid_i[0] = 1'b0;
    sb.push_back(expect_res(2'd1, 1000, 10, 12, 1'b0));
    exp = sb.pop_front(); collect(got, ok);
    checks++; if (!ok || got !== exp) begin errors++;
      $display("FAIL stall_next_hit: got %h (ok=%0d), expected %h", got, ok, exp); end
  endtask

  task automatic test_flush_respond();
    bit ok; res_t got, exp;
    flush_i = 1'b1;
    div_valid_i = 1'b1; div_product_i = 99;
    drive_req(0, 2'd1, 1000, 10, 13);
    #1;
    checks++; if (req_ready_o !== 2'b00) begin errors++;
      $display("FAIL idle_flush_ready: got %b, expected 00", req_ready_o); end
    @(negedge clk_i);
    flush_i = 1'b0; div_valid_i = 1'b0;
    #1;
    checks++; if (res_valid_o !== 1'b0) begin errors++;
      $display("FAIL idle_ignore: got res_valid %b, expected 0", res_valid_o); end
    wait_grant(0, ok);
    flush_i = 1'b1; res_ready_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0; res_ready_i = 1'b0;
    #1;
    checks++; if (res_valid_o !== 1'b0) begin errors++;
      $display("FAIL respond_flush: got res_valid %b, expected 0", res_valid_o); end
    drive_req(1, 2'd1, 1000, 10, 14);
    wait_grant(1, ok);
    sb.push_back(expect_res(2'd1, 1000, 10, 14, 1'b1));
    exp = sb.pop_front(); collect(got, ok);
    checks++; if (!ok || got !== exp) begin errors++;
      $display("FAIL flush_cache_kept: got %h (ok=%0d), expected %h", got, ok, exp); end
  endtask

  task automatic test_clk_en();
    bit ok; res_t got, exp;
    clk_en_i = 1'b0;
    drive_req(0, 2'd3, 99, 10, 15);
    #1;
    checks++; if (req_ready_o !== 2'b00) begin errors++;
      $display("FAIL clken_ready: got %b, expected 00", req_ready_o); end
    @(negedge clk_i);
    clk_en_i = 1'b1;
    wait_grant(0, ok);
    sb.push_back(expect_res(2'd3, 99, 10, 15, 1'b0));
    clk_en_i = 1'b0;
    #1;
    checks++; if (div_valid_o !== 1'b0) begin errors++;
      $display("FAIL clken_issue: got %b, expected 0", div_valid_o); end
    repeat (2) @(negedge clk_i);
    clk_en_i = 1'b1;
    serve_div(1, ok);
    clk_en_i = 1'b0; res_ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    #1;
    checks++; if (res_valid_o !== 1'b1) begin errors++;
      $display("FAIL clken_hold_result: got res_valid %b, expected 1", res_valid_o); end
    res_ready_i = 1'b0; clk_en_i = 1'b1;
    exp = sb.pop_front(); collect(got, ok);
    checks++; if (!ok || got !== exp) begin errors++;
      $display("FAIL clken_result: got %h (ok=%0d), expected %h", got, ok, exp); end
  endtask

  task automatic test_reset_mid();
    bit ok; res_t got, exp;
    drive_req(0, 2'd1, 100, 7, 16);
    wait_grant(0, ok);
    @(negedge clk_i);
    #2;
    rst_n_i = 1'b0;
    #1;
    checks++; if ({res_valid_o, div_valid_o, req_ready_o} !== 4'b0000) begin errors++;
      $display("FAIL reset_mid_outputs: got %b%b%b, expected 0000", res_valid_o, div_valid_o,
               req_ready_o); end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    div_valid_i = 1'b1; div_product_i = 55;
    @(negedge clk_i);
    div_valid_i = 1'b0;
    #1;
    checks++; if (res_valid_o !== 1'b0) begin errors++;
      $display("FAIL reset_mid_no_result: got %b, expected 0", res_valid_o); end
    drive_req(0, 2'd1, 100, 7, 17);
    wait_grant(0, ok);
    sb.push_back(expect_res(2'd1, 100, 7, 17, 1'b0));
    #1;
    checks++; if ({res_valid_o, div_valid_o} !== 2'b01) begin errors++;
      $display("FAIL reset_mid_cache_cleared: got valid/issue %b%b, expected 01", res_valid_o,
               div_valid_o); end
    serve_div(1, ok);
    exp = sb.pop_front(); collect(got, ok);
    checks++; if (!ok || got !== exp) begin errors++;
      $display("FAIL reset_mid_result: got %h (ok=%0d), expected %h", got, ok, exp); end
  endtask

  initial begin
    test_reset();
    test_arbitration();
    test_miss();
    test_hit();
    test_div_zero();
    test_flush_wait();
    test_stall();
    test_flush_respond();
    test_clk_en();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/division_scheduler.md
DIVISION_SCHEDULER -- requirements
Module: division_scheduler

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 Parameter TAG_WIDTH, default 6, instruction tag width.
REQ-003 clk_i  in  1  clock; all state rising-edge.
REQ-004 rst_n_i  in  1  reset, asynchronous, active-low.
REQ-005 clk_en_i  in  1  when low, all state holds and no handshake completes.
REQ-006 flush_i  in  1  kill in-flight operation.
REQ-007 req_valid_i  in  2  per-port request valid (port 0, port 1).
REQ-008 req_ready_o  out  2  per-port accept; at most one bit high.
REQ-009 req_dividend_i, req_divisor_i  in  2xDATA_WIDTH each  per-port operands.
REQ-010 req_operation_i  in  2xdiv_uop_t  per-port operation (DIV, DIVU, REM, REMU).
REQ-011 req_tag_i  in  2xTAG_WIDTH  per-port tag.
REQ-012 div_dividend_o, div_divisor_o  out  DATA_WIDTH  operands to division unit.
REQ-013 div_operation_o  out  div_uop_t  operation to division unit.
REQ-014 div_valid_o  out  1  one-cycle start pulse to division unit.
REQ-015 div_idle_i  in  1  division unit idle.
REQ-016 div_valid_i, div_product_i, div_zero_i  in  1/DATA_WIDTH/1  division unit result, valid, divide-by-zero.
REQ-017 res_valid_o  out  1  result valid, held until accepted.
REQ-018 res_ready_i  in  1  consumer accept.
REQ-019 res_product_o, res_zero_o, res_tag_o, res_port_o  out  DATA_WIDTH/1/TAG_WIDTH/1  result, exception, tag, originating port.

Function
REQ-020 FSM states: IDLE, ISSUE, WAIT, RESPOND, DRAIN.
REQ-021 IDLE: req_ready_o asserted combinationally for the granted port only when state is IDLE and clk_en_i is high.
REQ-022 Arbitration: round-robin; priority pointer names the favoured port; a lone valid is granted regardless of the pointer.
REQ-023 On every grant, the pointer shall move to the non-granted port.
REQ-024 A grant captures operands, operation, tag and port into holding registers.
REQ-025 Result cache: one entry (valid, dividend, divisor, operation, product, zero flag).
REQ-026 A grant whose operands and operation exactly equal a valid cache entry shall go to RESPOND next cycle with the cached product/zero and no div_valid_o pulse.
REQ-027 A grant that misses the cache shall go to ISSUE.
REQ-028 ISSUE: assert div_valid_o for exactly one cycle when div_idle_i is high, then go to WAIT; otherwise stay in ISSUE with div_valid_o low.
REQ-029 div_dividend_o, div_divisor_o and div_operation_o shall be driven from the holding registers and stay stable from ISSUE through WAIT.
REQ-030 WAIT: on div_valid_i, capture div_product_i and div_zero_i, write the cache, and go to RESPOND.
REQ-031 RESPOND: res_valid_o is high and outputs are stable; on res_ready_i go to IDLE the next cycle; no new grant is made in the same cycle.
REQ-032 Divide-by-zero results are cached with the zero flag set; a hit reproduces res_zero_o=1.
REQ-033 flush_i in ISSUE or RESPOND: go to IDLE next cycle; res_valid_o drops; the cache is unchanged.
REQ-034 flush_i in WAIT: go to DRAIN; the divider result, when it arrives, is discarded and not cached; then go to IDLE.
REQ-035 DRAIN: req_ready_o is all zero.
REQ-036 flush_i in IDLE: no grant that cycle.
REQ-037 flush_i has priority over a simultaneous res_ready_i or div_valid_i.
REQ-038 div_valid_i outside WAIT or DRAIN shall be ignored.
REQ-039 Latency: a cache hit gives res_valid_o 1 cycle after the grant; a miss gives res_valid_o 1 cycle after div_valid_i.

Reset
REQ-040 Asynchronous reset shall set: state IDLE, pointer at port 0, cache invalid, div_valid_o=0, res_valid_o=0, req_ready_o=0, res_zero_o=0, res_port_o=0, all data/tag outputs 0.
REQ-041 Reset mid-operation shall abandon the operation with no result emitted; the first request after reset shall miss the cache.

Verification
REQ-042 Both ports valid after reset -> port 0 granted; next grant goes to port 1 if both are still valid.
REQ-043 Port 1 DIVU 100/7, tag 5 -> one div_valid_o pulse; div_valid_i product 14 -> res_valid_o with 14, tag 5, port 1.
REQ-044 Repeat DIVU 100/7 -> res_valid_o 1 cycle after the grant, product 14, no div_valid_o pulse.
REQ-045 DIV 10/0 -> res_zero_o=1; an identical request is then a cache hit with res_zero_o=1.
REQ-046 flush_i in WAIT, then div_valid_i product 3 -> no res_valid_o; a re-request of the same operation misses the cache.
REQ-047 res_ready_i held low 5 cycles in RESPOND -> outputs stable and req_ready_o=0 throughout; the grant resumes the cycle after the state returns to IDLE.
